// File: rtl/pingpong_frame_ram.sv
// ============================================================================
// Module   : pingpong_frame_ram
// Brief    : Double-buffered (ping-pong) frame memory. The writer fills the
//            back bank while the scan side reads the front bank; a requested
//            bank swap is held until the next reader frame boundary.
//            Optional macro PINGPONG_BANK_CLEAR_EN adds a hardware engine that
//            fills the back bank with CLEAR_VAL after reset and after every
//            swap, holding wr_ready low while it runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_frame_ram #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 13,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    input  logic              frame_end,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_bank
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Both banks live in one array; the bank index is the address MSB.
    logic [DATA_W-1:0] r_mem [0:2*c_DEPTH-1];

    logic              r_front;
    logic              r_swap_pending;
    logic              r_swap_done;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_clearing;
    logic [ADDR_W-1:0] w_clear_addr;
    logic              w_wr_ready;
    logic              w_swap_fire;
    logic              w_mem_we;
    logic [ADDR_W:0]   w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

`ifdef PINGPONG_BANK_CLEAR_EN
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clear_cnt;
    logic [ADDR_W-1:0] w_clear_cnt_nxt;

    // Clear-engine state register; reset parks it at the start of a clear pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_CLEAR;
            r_clear_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_cnt <= w_clear_cnt_nxt;
        end
    end

    // Clear-engine next state: one word per cycle, restart on every swap edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_clear_cnt_nxt = r_clear_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_swap_fire) begin
                    w_state_nxt     = c_ST_CLEAR;
                    w_clear_cnt_nxt = '0;
                end
            end
            default: begin
                w_clear_cnt_nxt = r_clear_cnt + 1'b1;
                if (&r_clear_cnt) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    // Clearing is suppressed while reset is held so memory is untouched by rst.
    assign w_clearing   = (r_state == c_ST_CLEAR) && !rst;
    assign w_clear_addr = r_clear_cnt;
    assign w_wr_ready   = (r_state == c_ST_IDLE) && !rst;
`else
    assign w_clearing   = 1'b0;
    assign w_clear_addr = '0;
    assign w_wr_ready   = 1'b1;
`endif

    // A swap never executes while the back bank is still being cleared.
    assign w_swap_fire = (r_swap_pending || swap_req) && frame_end && !w_clearing;

    // Single write port shared by the writer and the clear engine (never both).
    assign w_mem_we    = w_clearing || (wr_en && w_wr_ready);
    assign w_mem_addr  = w_clearing ? {~r_front, w_clear_addr} : {~r_front, wr_addr};
    assign w_mem_wdata = w_clearing ? CLEAR_VAL : wr_data;

    // Back-bank write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Front-bank registered read with a valid flag that tracks rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_mem[{r_front, rd_addr}];
            end
        end
    end

    // Swap handshake: latch a request, execute it on a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_swap_done <= w_swap_fire;
            if (w_swap_fire) begin
                r_front        <= ~r_front;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    assign wr_ready     = w_wr_ready;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign swap_pending = r_swap_pending;
    assign swap_done    = r_swap_done;
    assign front_bank   = r_front;

endmodule

`default_nettype wire

// File: tb/tb_pingpong_frame_ram.sv
// ============================================================================
// Module   : tb_pingpong_frame_ram
// Brief    : Self-checking bench for pingpong_frame_ram (ADDR_W=4, DATA_W=8).
//            A bank/array model predicts every output each cycle; directed
//            scenarios add literal expectations. PINGPONG_BANK_CLEAR_EN
//            selects the clear-engine expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pingpong_frame_ram;

    localparam int          DW    = 8;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [7:0]  CV    = 8'h00;
`ifdef PINGPONG_BANK_CLEAR_EN
    localparam int          CLR_CYC = 16;
`else
    localparam int          CLR_CYC = 0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          swap_req;
    logic          frame_end;
    logic          swap_pending;
    logic          swap_done;
    logic          front_bank;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    pingpong_frame_ram #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(CV)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .swap_req(swap_req), .frame_end(frame_end),
        .swap_pending(swap_pending), .swap_done(swap_done), .front_bank(front_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    logic [7:0] m_mem [0:31];
    bit         m_front, m_pend, m_done, m_rvalid;
    logic [7:0] m_rdata;
    int         m_clear_left;

    function automatic bit m_ready();
`ifdef PINGPONG_BANK_CLEAR_EN
        return !rst && (m_clear_left == 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        m_front = 0; m_pend = 0; m_done = 0; m_rvalid = 0; m_rdata = 8'h00;
        m_clear_left = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    end

    // Model update at each edge, then compare DUT outputs 1 time unit later.
    always @(posedge clk) begin : p_model
        bit fire;
        bit wr_ok;
        wr_ok = wr_en && m_ready();
        fire  = !rst && (m_pend || swap_req) && frame_end && (m_clear_left == 0);
        if (wr_ok) m_mem[{~m_front, wr_addr}] = wr_data;
        if (!rst && m_clear_left > 0) begin
            m_mem[{~m_front, 4'(DEPTH - m_clear_left)}] = CV;
            m_clear_left--;
        end
        if (rst) begin
            m_front = 0; m_pend = 0; m_done = 0; m_rvalid = 0; m_rdata = 8'h00;
`ifdef PINGPONG_BANK_CLEAR_EN
            m_clear_left = DEPTH;
`endif
        end else begin
            m_rvalid = rd_en;
            if (rd_en) m_rdata = m_mem[{m_front, rd_addr}];
            m_done = fire;
            if (fire) begin
                m_front = ~m_front;
                m_pend  = 0;
`ifdef PINGPONG_BANK_CLEAR_EN
                m_clear_left = DEPTH;
`endif
            end else if (swap_req) begin
                m_pend = 1;
            end
        end
        #1;
        cmp("front_bank",   {7'd0, front_bank},   {7'd0, m_front});
        cmp("swap_pending", {7'd0, swap_pending}, {7'd0, m_pend});
        cmp("swap_done",    {7'd0, swap_done},    {7'd0, m_done});
        cmp("rd_valid",     {7'd0, rd_valid},     {7'd0, m_rvalid});
        cmp("rd_data",      rd_data,              m_rdata);
        cmp("wr_ready",     {7'd0, wr_ready},     {7'd0, m_ready()});
        if (swap_done === 1'b1) n_done++;
    end

    // -------------------------------------------------------------- stimulus
    task automatic drive(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                         input bit re, input logic [3:0] ra, input bit sr,
                         input bit fe, input bit r);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        swap_req = sr; frame_end = fe; rst = r;
    endtask

    task automatic idle();                           drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d); drive(1, a, d, 0, 0, 0, 0, 0); endtask
    task automatic rd(input logic [3:0] a);          drive(0, 0, 0, 1, a, 0, 0, 0); endtask
    task automatic req();                            drive(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic fend();                           drive(0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic both();                           drive(0, 0, 0, 0, 0, 1, 1, 0); endtask

    // Counts negedge samples with wr_ready low, bounded.
    task automatic wait_ready(output int k);
        k = 0;
        while (wr_ready !== 1'b1 && k < 40) begin
            k++;
            @(negedge clk);
        end
        if (k >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready timeout: wr_ready=%b required 1", wr_ready);
        end
    endtask

    initial begin : p_main
        int k;
        int d0;
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
        swap_req = 0; frame_end = 0; rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        // reset state
        cmp("rst_front",   {7'd0, front_bank},   8'h00);
        cmp("rst_pending", {7'd0, swap_pending}, 8'h00);
        cmp("rst_done",    {7'd0, swap_done},    8'h00);
        cmp("rst_rvalid",  {7'd0, rd_valid},     8'h00);
        cmp("rst_rdata",   rd_data,              8'h00);
        cmp("rst_wready",  {7'd0, wr_ready},     (CLR_CYC == 0) ? 8'h01 : 8'h00);

        idle();
        wait_ready(k);
        cmp("ready_after_rst", 8'(k), 8'(CLR_CYC));

        // fill both banks so every later read has known contents
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
        both(); idle(); wait_ready(k);
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h20 + i));
        both(); idle(); wait_ready(k);

        // basic write/read across a swap
        wr(4'd3, 8'hA5);
        req(); fend(); idle();
        cmp("t1_front", {7'd0, front_bank}, 8'h01);
        cmp("t1_done",  {7'd0, swap_done},  8'h01);
        wait_ready(k);
        cmp("ready_after_swap", 8'(k), 8'(CLR_CYC));
        rd(4'd3); idle();
        cmp("t1_rdata",  rd_data,            8'hA5);
        cmp("t1_rvalid", {7'd0, rd_valid},   8'h01);

        // frame-boundary deferral
        req(); idle();
        cmp("t2_pending", {7'd0, swap_pending}, 8'h01);
        repeat (4) idle();
        rd(4'd3); idle();
        cmp("t2_old_bank", rd_data, 8'hA5);
        wr(4'd3, 8'h5A);
        repeat (5) idle();
        cmp("t2_front_held", {7'd0, front_bank}, 8'h01);
        fend(); idle();
        cmp("t2_front", {7'd0, front_bank}, 8'h00);
        rd(4'd3); idle();
        cmp("t2_new_bank", rd_data, 8'h5A);

        // repeated requests: one toggle, one swap_done
        wait_ready(k);
        d0 = n_done;
        req(); idle(); req(); idle(); req(); fend(); idle(); idle(); idle();
        cmp("t3_done_cnt", 8'(n_done - d0), 8'h01);
        cmp("t3_front", {7'd0, front_bank}, 8'h01);

`ifdef PINGPONG_BANK_CLEAR_EN
        // request plus frame_end while clearing stays pending
        both(); idle();
        cmp("t5_pending", {7'd0, swap_pending}, 8'h01);
        cmp("t5_front",   {7'd0, front_bank},   8'h01);
        wait_ready(k);
        fend(); idle();
        cmp("t5_front2",  {7'd0, front_bank},   8'h00);
        cmp("t5_pending2", {7'd0, swap_pending}, 8'h00);
        wait_ready(k);
        both(); idle();
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle();
        cmp("t5_cleared", rd_data, CV);
        wait_ready(k);
`endif

        // reset mid-operation
        wait_ready(k);
        req(); idle();
        cmp("t4_pre_pending", {7'd0, swap_pending}, 8'h01);
        cmp("t4_pre_front",   {7'd0, front_bank},   8'h01);
        drive(0, 0, 0, 1, 4'd3, 0, 0, 1);
        idle();
        cmp("t4_front",   {7'd0, front_bank},   8'h00);
        cmp("t4_pending", {7'd0, swap_pending}, 8'h00);
        cmp("t4_rvalid",  {7'd0, rd_valid},     8'h00);
        cmp("t4_rdata",   rd_data,              8'h00);
        wait_ready(k);
        rd(4'd5); idle();
`ifndef PINGPONG_BANK_CLEAR_EN
        cmp("t4_retained", rd_data, 8'h25);
`endif
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
